// File: rtl/ram_stream_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_stream_sched_if
// Purpose  : Control, RAM read-port and output-stream bundle for ram_stream_sched
// Revision : 1.0 - initial release
// ============================================================================
interface ram_stream_sched_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 8
) ();
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] len;
   logic              busy;
   logic              done;
   logic [3:0]        ram_en;
   logic [ADDR_W-1:0] ram_addr;
   logic [WIDTH-1:0]  ram_rdata_0;
   logic [WIDTH-1:0]  ram_rdata_1;
   logic [WIDTH-1:0]  ram_rdata_2;
   logic [WIDTH-1:0]  ram_rdata_3;
   logic [WIDTH-1:0]  out_data;
   logic              out_valid;
   logic              out_ready;
   logic [1:0]        out_bank;
   logic              out_last;

   // Scheduler side
   modport slave (
      input  start, base_addr, len,
      input  ram_rdata_0, ram_rdata_1, ram_rdata_2, ram_rdata_3,
      input  out_ready,
      output busy, done, ram_en, ram_addr,
      output out_data, out_valid, out_bank, out_last
   );

   // Controller / RAM / sink side
   modport master (
      output start, base_addr, len,
      output ram_rdata_0, ram_rdata_1, ram_rdata_2, ram_rdata_3,
      output out_ready,
      input  busy, done, ram_en, ram_addr,
      input  out_data, out_valid, out_bank, out_last
   );
endinterface
`default_nettype wire

// File: rtl/ram_stream_sched.sv
`default_nettype none
// ============================================================================
// Module   : ram_stream_sched
// Purpose  : Streams 4-bank RAM operands into a credit-tracked output FIFO
// Revision : 1.0 - initial release
// ============================================================================
module ram_stream_sched #(
   parameter int WIDTH      = 16,
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  wire logic          clk,
   input  wire logic          rst,
   ram_stream_sched_if.slave  bus
);

   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W:0] c_DEPTH = FIFO_DEPTH[c_CNT_W:0];

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [ADDR_W-1:0]   r_cur_addr;
   logic [ADDR_W-1:0]   r_left;
   logic [1:0]          r_bank;

   logic                r_pipe_valid;
   logic [1:0]          r_pipe_bank;
   logic                r_pipe_last;

   logic [WIDTH-1:0]    r_mem_data [FIFO_DEPTH];
   logic [1:0]          r_mem_bank [FIFO_DEPTH];
   logic                r_mem_last [FIFO_DEPTH];
   logic [c_PTR_W-1:0]  r_wr_ptr;
   logic [c_PTR_W-1:0]  r_rd_ptr;
   logic [c_CNT_W-1:0]  r_count;

   logic                w_issue;
   logic                w_last_issue;
   logic                w_valid;
   logic                w_pop;
   logic                w_accept;
   logic [WIDTH-1:0]    w_push_data;

   // Credits cover both buffered words and the read still in the return pipe
   assign w_issue      = (r_state == S_RUN) &&
                         (({1'b0, r_count} + {{c_CNT_W{1'b0}}, r_pipe_valid}) < c_DEPTH);
   assign w_last_issue = w_issue && (r_bank == 2'd3) && (r_left == ADDR_W'(1));
   assign w_valid      = (r_count != '0);
   assign w_pop        = w_valid && bus.out_ready;
   assign w_accept     = (r_state == S_IDLE) && bus.start;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = (bus.len != '0) ? S_RUN : S_DONE;
         S_RUN:   if (w_last_issue) w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_pop && r_mem_last[r_rd_ptr]) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cur_addr <= '0;
         r_left     <= '0;
         r_bank     <= '0;
      end else if (w_accept) begin
         r_cur_addr <= bus.base_addr;
         r_left     <= bus.len;
         r_bank     <= '0;
      end else if (w_issue) begin
         r_bank <= r_bank + 2'd1;
         if (r_bank == 2'd3) begin
            r_cur_addr <= r_cur_addr + ADDR_W'(1);
            r_left     <= r_left - ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pipe_valid <= 1'b0;
         r_pipe_bank  <= '0;
         r_pipe_last  <= 1'b0;
      end else begin
         r_pipe_valid <= w_issue;
         r_pipe_bank  <= r_bank;
         r_pipe_last  <= w_last_issue;
      end
   end

   always_comb begin
      w_push_data = bus.ram_rdata_0;
      case (r_pipe_bank)
         2'd1:    w_push_data = bus.ram_rdata_1;
         2'd2:    w_push_data = bus.ram_rdata_2;
         2'd3:    w_push_data = bus.ram_rdata_3;
         default: w_push_data = bus.ram_rdata_0;
      endcase
   end

   // Storage needs no reset: the head is masked whenever the FIFO is empty
   always_ff @(posedge clk) begin
      if (r_pipe_valid) begin
         r_mem_data[r_wr_ptr] <= w_push_data;
         r_mem_bank[r_wr_ptr] <= r_pipe_bank;
         r_mem_last[r_wr_ptr] <= r_pipe_last;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (r_pipe_valid) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (w_pop)        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         case ({r_pipe_valid, w_pop})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.busy      = (r_state != S_IDLE);
   assign bus.done      = (r_state == S_DONE);
   assign bus.ram_en    = w_issue ? (4'b0001 << r_bank) : 4'b0000;
   assign bus.ram_addr  = w_issue ? r_cur_addr : '0;
   assign bus.out_valid = w_valid;
   assign bus.out_data  = w_valid ? r_mem_data[r_rd_ptr] : '0;
   assign bus.out_bank  = w_valid ? r_mem_bank[r_rd_ptr] : 2'd0;
   assign bus.out_last  = w_valid ? r_mem_last[r_rd_ptr] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ram_stream_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_stream_sched
// Purpose  : Directed scoreboard bench for ram_stream_sched
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_stream_sched;

   localparam int WIDTH  = 16;
   localparam int ADDR_W = 8;

   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  bank;
      logic        last;
   } word_t;

   typedef struct packed {
      logic [1:0] bank;
      logic [7:0] addr;
   } rd_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   issued;
   int   popped;
   int   fv, lc, dc;

   word_t sb[$];
   rd_t   iq[$];

   always #5 clk = ~clk;

   ram_stream_sched_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

   ram_stream_sched #(
      .WIDTH      (WIDTH),
      .ADDR_W     (ADDR_W),
      .FIFO_DEPTH (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [15:0] ram_val(input logic [1:0] b, input logic [7:0] a);
      return {b, 6'h2A, a};
   endfunction

   // Four single-port RAM banks with one-cycle read latency
   always @(posedge clk) begin
      if (bus.ram_en[0]) bus.ram_rdata_0 <= ram_val(2'd0, bus.ram_addr);
      if (bus.ram_en[1]) bus.ram_rdata_1 <= ram_val(2'd1, bus.ram_addr);
      if (bus.ram_en[2]) bus.ram_rdata_2 <= ram_val(2'd2, bus.ram_addr);
      if (bus.ram_en[3]) bus.ram_rdata_3 <= ram_val(2'd3, bus.ram_addr);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [7:0] b, input logic [7:0] l);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.base_addr = b;
      bus.len       = l;
      for (int a = 0; a < int'(l); a++) begin
         for (int k = 0; k < 4; k++) begin
            logic [7:0] ad;
            ad = b + 8'(a);
            iq.push_back('{bank: 2'(k), addr: ad});
            sb.push_back('{data: ram_val(2'(k), ad), bank: 2'(k),
                           last: (a == int'(l) - 1) && (k == 3)});
         end
      end
      issued = 0;
      popped = 0;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic stream(input bit rnd, input int abort_words, input bit restart,
                         output int first_valid, output int last_cyc, output int done_cyc);
      int    cyc;
      bit    fin;
      word_t w;
      rd_t   r;
      first_valid = -1;
      last_cyc    = -1;
      done_cyc    = -1;
      cyc         = 1;
      fin         = 1'b0;
      w           = '0;
      while (!fin) begin
         bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (restart) begin
            bus.start     = (cyc == 6);
            bus.base_addr = 8'h40;
            bus.len       = 8'd5;
         end
         #1;
         if (bus.ram_en != 4'd0) begin
            check("issue_expected", 64'(iq.size() != 0), 64'(1));
            if (iq.size() != 0) begin
               r = iq.pop_front();
               check("ram_en", 64'(bus.ram_en), 64'(4'b0001 << r.bank));
               check("ram_addr", 64'(bus.ram_addr), 64'(r.addr));
               check("credit", 64'((issued - popped) < 4), 64'(1));
               issued++;
            end
         end
         if (bus.out_valid && first_valid < 0) first_valid = cyc;
         if (bus.out_valid && bus.out_ready) begin
            check("word_expected", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
               w = sb.pop_front();
               check("word", 64'({bus.out_data, bus.out_bank, bus.out_last}), 64'(w));
               if (w.last) last_cyc = cyc;
            end
            popped++;
            if (abort_words > 0 && popped == abort_words) fin = 1'b1;
         end
         if (!fin) begin
            check("busy", 64'(bus.busy), 64'(1));
            if (bus.done) begin
               done_cyc = cyc;
               fin      = 1'b1;
            end else if (cyc >= 300) begin
               check("stream_timeout", 64'(cyc), 64'(0));
               fin = 1'b1;
            end
         end
         if (!fin) begin
            @(negedge clk);
            cyc++;
         end
      end
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk);
      #1;
      check(tag, 64'({bus.busy, bus.done, bus.ram_en}), 64'(0));
   endtask

   task automatic outs_zero(input string tag);
      check(tag, 64'({bus.busy, bus.done, bus.ram_en, bus.ram_addr, bus.out_data,
                      bus.out_valid, bus.out_bank, bus.out_last}), 64'(0));
   endtask

   initial begin
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.len       = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      outs_zero("reset_outputs");
      @(negedge clk);
      rst = 1'b0;

      // Nominal stream, sink always ready
      do_start(8'h10, 8'd2);
      stream(1'b0, 0, 1'b0, fv, lc, dc);
      check("t1_first_valid", 64'(fv), 64'(3));
      check("t1_last_cycle", 64'(lc), 64'(10));
      check("t1_done_cycle", 64'(dc), 64'(11));
      check("t1_sb_empty", 64'(sb.size() + iq.size()), 64'(0));
      idle_check("t1_idle_after_done");

      // Same stream under random backpressure
      do_start(8'h10, 8'd2);
      stream(1'b1, 0, 1'b0, fv, lc, dc);
      check("t2_done_after_last", 64'(dc), 64'(lc + 1));
      check("t2_sb_empty", 64'(sb.size() + iq.size()), 64'(0));
      idle_check("t2_idle_after_done");

      // Address wrap
      do_start(8'hFE, 8'd3);
      stream(1'b0, 0, 1'b0, fv, lc, dc);
      check("t3_last_cycle", 64'(lc), 64'(14));
      check("t3_done_cycle", 64'(dc), 64'(15));
      check("t3_sb_empty", 64'(sb.size() + iq.size()), 64'(0));
      idle_check("t3_idle_after_done");

      // Zero length
      do_start(8'h33, 8'd0);
      stream(1'b0, 0, 1'b0, fv, lc, dc);
      check("t4_done_cycle", 64'(dc), 64'(1));
      check("t4_no_valid", 64'(fv), 64'(-1));
      idle_check("t4_idle_after_done");

      // Start pulse mid-stream must be ignored
      do_start(8'h10, 8'd2);
      stream(1'b0, 0, 1'b1, fv, lc, dc);
      check("t5_last_cycle", 64'(lc), 64'(10));
      check("t5_done_cycle", 64'(dc), 64'(11));
      check("t5_sb_empty", 64'(sb.size() + iq.size()), 64'(0));
      idle_check("t5_idle_after_done");

      // Reset after five words, then a fresh stream
      do_start(8'h10, 8'd2);
      stream(1'b0, 5, 1'b0, fv, lc, dc);
      check("t6_words_before_abort", 64'(popped), 64'(5));
      rst = 1'b1;
      #1;
      outs_zero("t6_outputs_on_reset");
      sb.delete();
      iq.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) idle_check("t6_no_done_after_abort");
      do_start(8'h20, 8'd1);
      stream(1'b0, 0, 1'b0, fv, lc, dc);
      check("t6_first_valid", 64'(fv), 64'(3));
      check("t6_last_cycle", 64'(lc), 64'(6));
      check("t6_done_cycle", 64'(dc), 64'(7));
      check("t6_sb_empty", 64'(sb.size() + iq.size()), 64'(0));
      idle_check("t6_idle_after_done");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ram_stream_sched.md
Name: ram_stream_sched

Overview:
- Read scheduler that streams operand words from four single-port synchronous input RAM banks into the matrix-multiply array input.
- On `start`, it walks `len` consecutive addresses from `base_addr`. At each address it reads banks 0,1,2,3 in turn, producing 4*len words.
- Words leave on a valid/ready stream.
- A small credit-tracked output FIFO absorbs the fixed RAM read latency, so downstream backpressure never drops or duplicates a word.

Parameters:
- WIDTH, 16, data word width.
- ADDR_W, 8, RAM address width; also the width of len.
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=3 for full throughput).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a stream; sampled only in IDLE.
- base_addr  input  ADDR_W  first RAM address; captured when start is accepted.
- len  input  ADDR_W  addresses per stream; captured when start is accepted.
- busy  output  1  high from start acceptance through the done cycle.
- done  output  1  one-cycle pulse when the stream completes.
- ram_en  output  4  one-hot bank read enable.
- ram_addr  output  ADDR_W  shared read address.
- ram_rdata_0..ram_rdata_3  input  WIDTH each  bank read data, valid the cycle after ram_en.
- out_data  output  WIDTH  streamed word (FIFO head).
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accept.
- out_bank  output  2  source bank of out_data.
- out_last  output  1  high with the final word of the stream.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; FIFO and in-flight pipe emptied.
  - Address counter and bank counter cleared.
  - All outputs 0: busy, done, ram_en, ram_addr, out_data, out_valid, out_bank, out_last.
- States:
  - IDLE: start=1 captures base_addr/len. Go to RUN if len!=0, else go straight to DONE. busy rises the cycle after the accepting edge.
  - RUN: issue reads. After the final read (bank 3 at address base+len-1) is issued, go to DRAIN.
  - DRAIN: no issues. Go to DONE on the edge where the out_last word handshakes (out_valid & out_ready).
  - DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Issue rule:
  - In RUN, a read is issued when count + inflight < FIFO_DEPTH.
  - count = FIFO occupancy; inflight = number of reads in the 1-stage return pipe (0..1).
  - An issue drives ram_en = one-hot(bank) and ram_addr = cur_addr in the same cycle.
  - bank steps 0→1→2→3→0. cur_addr increments when bank wraps 3→0.
  - Address arithmetic is mod 2^ADDR_W: base=0xFF, len=2 reads 0xFF then 0x00.
- Return path:
  - Issue-cycle tags (bank, last) are registered.
  - The next cycle, ram_rdata_<bank> is pushed into the FIFO with its tags.
- Output: out_data, out_bank and out_last come from the FIFO head. out_valid = (count != 0). Pop on out_valid & out_ready.
- Simultaneous push and pop in one cycle leave count unchanged. FIFO overflow is impossible by construction.
- Latency:
  - Accepting edge T0 → ram_en[0] asserted in cycle 1 → push at T2 → out_valid=1 in cycle 3.
  - With out_ready held high: one word per cycle sustained; the final word appears 4*len+2 cycles after T0.
- start while busy is ignored; it has no effect on captured values.
- ram_en is never asserted outside RUN.
- A reset mid-stream abandons the stream. No done is produced, and the next start behaves as from power-up.

Test Plan:
- base=0x10, len=2, out_ready=1 → 8 words, banks 0,1,2,3,0,1,2,3, addresses 0x10,0x10,0x10,0x10,0x11,...; first out_valid 3 cycles after start; out_last on word 8; done one cycle later; busy covers the whole stream.
- Same stream with out_ready toggled pseudo-randomly → identical word sequence, no loss or duplication; count+inflight never exceeds 4; ram_en low whenever credits are exhausted.
- base=0xFE, len=3 → address sequence 0xFE, 0xFF, 0x00, each repeated for banks 0-3; 12 words total.
- len=0 start → no ram_en ever; done pulse 1 cycle after acceptance; out_valid stays 0.
- start re-pulsed with base=0x40 mid-stream → ignored; original stream completes unchanged.
- rst asserted after 5 words, then start with base=0x20, len=1 → all outputs 0 immediately; no done for the aborted stream; new stream emits 4 words from 0x20 with correct timing.
